udp_wave_router: RTL and testbench

Packet-level receive controller between the UDP receive path and the two DA sample FIFOs (channel A, channel B). It parses a 3-byte header on every UDP packet (channel select, 16-bit frequency word), routes the remaining payload bytes into the selected channel's FIFO, and publishes the scaled frequency for that channel. It also sequences FIFO readout with a start threshold and empty-stop hysteresis, and keeps drop and error counters for bring-up.

---
 rtl/udp_wave_router.sv | 211 +++++++++++++++++++++
 tb/tb_udp_wave_router.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_wave_router.sv
// udp_wave_router
//   Receive-side packet controller between the UDP receive path and the two
//   DA sample FIFOs. Each packet starts with a 3-byte header: a channel byte
//   (0x01 = A, 0x02 = B) and a 16-bit raw frequency word, high byte first.
//   The rest of the packet is payload and is written to the selected FIFO.
//   The scaled frequency min(raw*4/5, 8191) is published for that channel.
//   Playback read enables use a start threshold with an empty stop
//   (hysteresis). Saturating drop and error counters are kept for bring-up.
//
//   Optional build macro WAVE_ROUTER_LEN_CHECK_EN: when defined, the number
//   of accepted bytes is checked against rec_byte_num at end of packet.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   udp_rec_en/udp_rec_data    received payload byte strobe and data
//   rec_pkt_done/rec_byte_num  end-of-packet pulse and packet byte count
//   wr_data_count_a/b, full_a/b  FIFO fill levels and full flags
//   wr_en_a/b, fifo_in_a/b     FIFO write enables and data (registered)
//   rd_en_a/b                  playback read enables (registered)
//   freq_a/b, freq_upd_a/b     scaled frequency and one-cycle update pulse
//   drop_cnt, err_cnt          saturating drop / malformed-packet counters
module udp_wave_router #(
  parameter int unsigned START_LEVEL = 10,
  parameter int unsigned CNT_W       = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             udp_rec_en,
  input  logic [7:0]       udp_rec_data,
  input  logic             rec_pkt_done,
  input  logic [15:0]      rec_byte_num,
  input  logic [CNT_W-1:0] wr_data_count_a,
  input  logic [CNT_W-1:0] wr_data_count_b,
  input  logic             full_a,
  input  logic             full_b,
  output logic             wr_en_a,
  output logic             wr_en_b,
  output logic [7:0]       fifo_in_a,
  output logic [7:0]       fifo_in_b,
  output logic             rd_en_a,
  output logic             rd_en_b,
  output logic [12:0]      freq_a,
  output logic [12:0]      freq_b,
  output logic             freq_upd_a,
  output logic             freq_upd_b,
  output logic [15:0]      drop_cnt,
  output logic [7:0]       err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_FH,
    S_HDR_FL,
    S_PAYLOAD,
    S_DISCARD
  } state_t;

  state_t      r_state;
  state_t      w_state_byte;
  state_t      w_state_nxt;

  logic        r_sel;        // 0 = channel A, 1 = channel B
  logic [7:0]  r_raw_hi;
  logic        r_cap_vld;
  logic        r_cap_sel;
  logic [15:0] r_cap_raw;

  logic        w_bad_ch;
  logic        w_sel_ld;
  logic        w_sel_val;
  logic        w_hi_ld;
  logic        w_cap;
  logic        w_pay;
  logic        w_short;
  logic        w_len_err;
  logic        w_err_evt;
  logic        w_full_sel;
  logic [17:0] w_scaled;
  logic [12:0] w_freq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // The byte of this cycle is processed first (w_state_byte); an end-of-packet
  // pulse then overrides the destination, so "short packet" is judged on the
  // state reached after the byte.
  always_comb begin
    w_state_byte = r_state;
    w_bad_ch     = 1'b0;
    w_sel_ld     = 1'b0;
    w_sel_val    = r_sel;
    w_hi_ld      = 1'b0;
    w_cap        = 1'b0;
    w_pay        = 1'b0;
    if (udp_rec_en) begin
      case (r_state)
        S_IDLE: begin
          if (udp_rec_data == 8'h01) begin
            w_sel_ld     = 1'b1;
            w_sel_val    = 1'b0;
            w_state_byte = S_HDR_FH;
          end else if (udp_rec_data == 8'h02) begin
            w_sel_ld     = 1'b1;
            w_sel_val    = 1'b1;
            w_state_byte = S_HDR_FH;
          end else begin
            w_bad_ch     = 1'b1;
            w_state_byte = S_DISCARD;
          end
        end
        S_HDR_FH: begin
          w_hi_ld      = 1'b1;
          w_state_byte = S_HDR_FL;
        end
        S_HDR_FL: begin
          w_cap        = 1'b1;
          w_state_byte = S_PAYLOAD;
        end
        S_PAYLOAD: w_pay = 1'b1;
        S_DISCARD: w_state_byte = S_DISCARD;
        default:   w_state_byte = S_IDLE;
      endcase
    end
    w_short     = rec_pkt_done &&
                  ((w_state_byte == S_HDR_FH) || (w_state_byte == S_HDR_FL));
    w_state_nxt = rec_pkt_done ? S_IDLE : w_state_byte;
  end

  assign w_full_sel = r_sel ? full_b : full_a;
  assign w_scaled   = {r_cap_raw, 2'b00} / 18'd5;
  assign w_freq     = (w_scaled > 18'd8191) ? 13'h1FFF : w_scaled[12:0];

`ifdef WAVE_ROUTER_LEN_CHECK_EN
  logic [15:0] r_len;
  logic        r_pkt_flag;
  logic [15:0] w_len_total;

  assign w_len_total = r_len + 16'(udp_rec_en);
  // Packets already counted as bad (channel byte or short) are not counted again.
  assign w_len_err   = rec_pkt_done && !(r_pkt_flag || w_bad_ch || w_short) &&
                       (w_len_total != rec_byte_num);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_pkt_flag <= 1'b0;
    end else begin
      r_len      <= rec_pkt_done ? '0 : w_len_total;
      r_pkt_flag <= rec_pkt_done ? 1'b0 : (r_pkt_flag | w_bad_ch);
    end
  end
`else
  logic w_unused_byte_num;
  assign w_unused_byte_num = ^rec_byte_num;
  assign w_len_err         = 1'b0;
`endif

  assign w_err_evt = w_bad_ch | w_short | w_len_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel      <= 1'b0;
      r_raw_hi   <= '0;
      r_cap_vld  <= 1'b0;
      r_cap_sel  <= 1'b0;
      r_cap_raw  <= '0;
      wr_en_a    <= 1'b0;
      wr_en_b    <= 1'b0;
      fifo_in_a  <= '0;
      fifo_in_b  <= '0;
      rd_en_a    <= 1'b0;
      rd_en_b    <= 1'b0;
      freq_a     <= '0;
      freq_b     <= '0;
      freq_upd_a <= 1'b0;
      freq_upd_b <= 1'b0;
      drop_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      if (w_sel_ld) r_sel    <= w_sel_val;
      if (w_hi_ld)  r_raw_hi <= udp_rec_data;

      // Capture stage, then scale stage one cycle later.
      r_cap_vld <= w_cap;
      if (w_cap) begin
        r_cap_raw <= {r_raw_hi, udp_rec_data};
        r_cap_sel <= r_sel;
      end
      freq_upd_a <= r_cap_vld & ~r_cap_sel;
      freq_upd_b <= r_cap_vld &  r_cap_sel;
      if (r_cap_vld &  r_cap_sel) freq_b <= w_freq;
      if (r_cap_vld & ~r_cap_sel) freq_a <= w_freq;

      wr_en_a <= w_pay & ~r_sel & ~full_a;
      wr_en_b <= w_pay &  r_sel & ~full_b;
      if (w_pay & ~r_sel) fifo_in_a <= udp_rec_data;
      if (w_pay &  r_sel) fifo_in_b <= udp_rec_data;

      if (w_pay && w_full_sel && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      if (w_err_evt && (err_cnt != 8'hFF))              err_cnt  <= err_cnt + 8'd1;

      if (wr_data_count_a >= CNT_W'(START_LEVEL)) rd_en_a <= 1'b1;
      else if (wr_data_count_a == '0)             rd_en_a <= 1'b0;
      if (wr_data_count_b >= CNT_W'(START_LEVEL)) rd_en_b <= 1'b1;
      else if (wr_data_count_b == '0)             rd_en_b <= 1'b0;
    end
  end

endmodule

// File: tb/tb_udp_wave_router.sv
// tb_udp_wave_router
//   Table of packets with hand-computed cumulative expectations, plus
//   directed sequences for readout hysteresis, header/payload latency,
//   back-to-back packets and mid-packet asynchronous reset.
module tb_udp_wave_router;
  localparam int unsigned CNT_W = 13;
`ifdef WAVE_ROUTER_LEN_CHECK_EN
  localparam int LEN_ERR = 1;
`else
  localparam int LEN_ERR = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             udp_rec_en = 1'b0;
  logic [7:0]       udp_rec_data = '0;
  logic             rec_pkt_done = 1'b0;
  logic [15:0]      rec_byte_num = '0;
  logic [CNT_W-1:0] wr_data_count_a = '0;
  logic [CNT_W-1:0] wr_data_count_b = '0;
  logic             full_a = 1'b0;
  logic             full_b = 1'b0;
  logic             wr_en_a, wr_en_b, rd_en_a, rd_en_b, freq_upd_a, freq_upd_b;
  logic [7:0]       fifo_in_a, fifo_in_b, err_cnt;
  logic [12:0]      freq_a, freq_b;
  logic [15:0]      drop_cnt;

  udp_wave_router #(.START_LEVEL(10), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .udp_rec_en(udp_rec_en), .udp_rec_data(udp_rec_data),
    .rec_pkt_done(rec_pkt_done), .rec_byte_num(rec_byte_num),
    .wr_data_count_a(wr_data_count_a), .wr_data_count_b(wr_data_count_b),
    .full_a(full_a), .full_b(full_b),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b),
    .fifo_in_a(fifo_in_a), .fifo_in_b(fifo_in_b),
    .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
    .freq_a(freq_a), .freq_b(freq_b),
    .freq_upd_a(freq_upd_a), .freq_upd_b(freq_upd_b),
    .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ch;
    logic [15:0] raw;
    int n, trunc, full_s, full_l;
    bit done_sep;
    int bn_delta;
    int fa, fb, wa, wb, ua, ub, err, drop;
  } vec_t;

  typedef struct { int cnt; int rd; } rd_vec_t;

  vec_t    vecs[12];
  rd_vec_t rv[9];
  int n_vec = 0, n_bad = 0;
  int n_wa = 0, n_wb = 0, n_ua = 0, n_ub = 0;
  int wa0, wb0, ua0, ub0;
  logic [7:0] q_a[$], q_b[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] ch, input logic [15:0] raw,
      input int n, input int trunc, input int fs, input int fl, input bit ds,
      input int bnd, input int fa, input int fb, input int wa, input int wb,
      input int ua, input int ub, input int err, input int drop);
    vec_t v;
    v.ch = ch; v.raw = raw; v.n = n; v.trunc = trunc; v.full_s = fs; v.full_l = fl;
    v.done_sep = ds; v.bn_delta = bnd; v.fa = fa; v.fb = fb; v.wa = wa; v.wb = wb;
    v.ua = ua; v.ub = ub; v.err = err; v.drop = drop;
    return v;
  endfunction

  // Write monitor: every write must match the next byte the bench routed.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en_a) begin
        n_wa++;
        if (q_a.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL wr_a_unexpected: got write of %0d expected no write", fifo_in_a);
        end else chk("fifo_in_a", int'(fifo_in_a), int'(q_a.pop_front()));
      end
      if (wr_en_b) begin
        n_wb++;
        if (q_b.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL wr_b_unexpected: got write of %0d expected no write", fifo_in_b);
        end else chk("fifo_in_b", int'(fifo_in_b), int'(q_b.pop_front()));
      end
      if (freq_upd_a) n_ua++;
      if (freq_upd_b) n_ub++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      udp_rec_en = 1'b0; rec_pkt_done = 1'b0; full_a = 1'b0; full_b = 1'b0;
    end
  endtask

  task automatic send_pkt(input vec_t v, input int seed);
    int total;
    logic [7:0] b;
    logic fl;
    total = 3 + v.n;
    if (v.trunc > 0) total = v.trunc;
    for (int i = 0; i < total; i++) begin
      fl = 1'b0;
      if (i == 0)      b = v.ch;
      else if (i == 1) b = v.raw[15:8];
      else if (i == 2) b = v.raw[7:0];
      else begin
        b  = 8'(seed + (i - 3) * 13);
        fl = ((i - 3) >= v.full_s) && ((i - 3) < v.full_s + v.full_l);
      end
      @(negedge clk);
      udp_rec_en   = 1'b1;
      udp_rec_data = b;
      full_a       = fl && (v.ch == 8'h01);
      full_b       = fl && (v.ch == 8'h02);
      rec_pkt_done = (i == total - 1) && !v.done_sep;
      rec_byte_num = 16'(total + v.bn_delta);
      if (i >= 3 && !fl) begin
        if (v.ch == 8'h01)      q_a.push_back(b);
        else if (v.ch == 8'h02) q_b.push_back(b);
      end
    end
    if (v.done_sep) begin
      @(negedge clk);
      udp_rec_en = 1'b0; full_a = 1'b0; full_b = 1'b0; rec_pkt_done = 1'b1;
    end
  endtask

  task automatic snap();
    wa0 = n_wa; wb0 = n_wb; ua0 = n_ua; ub0 = n_ub;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          ch     raw     n  tr fs fl ds bnd      fa    fb  wa  wb ua ub err          drop
    vecs[0]  = mk(8'h01, 16'h03E8, 20, 0, 0, 0, 0, 0,    800,    0, 20, 0, 1, 0, 0,           0);
    vecs[1]  = mk(8'h02, 16'hFFFF,  8, 0, 0, 0, 0, 0,    800, 8191,  0, 8, 0, 1, 0,           0);
    vecs[2]  = mk(8'h07, 16'h0000,  7, 0, 0, 0, 0, 0,    800, 8191,  0, 0, 0, 0, 1,           0);
    vecs[3]  = mk(8'h01, 16'h0005,  4, 0, 0, 0, 0, 0,      4, 8191,  4, 0, 1, 0, 1,           0);
    vecs[4]  = mk(8'h01, 16'h1200,  0, 2, 0, 0, 1, 0,      4, 8191,  0, 0, 0, 0, 2,           0);
    vecs[5]  = mk(8'h02, 16'h3400,  0, 2, 0, 0, 0, 0,      4, 8191,  0, 0, 0, 0, 3,           0);
    vecs[6]  = mk(8'h02, 16'h000B,  0, 0, 0, 0, 0, 0,      4,    8,  0, 0, 0, 1, 3,           0);
    vecs[7]  = mk(8'h01, 16'h0064, 20, 0, 6, 5, 0, 0,     80,    8, 15, 0, 1, 0, 3,           5);
    vecs[8]  = mk(8'h02, 16'h0002,  5, 0, 0, 5, 1, 0,     80,    1,  0, 0, 0, 1, 3,          10);
    vecs[9]  = mk(8'h01, 16'h27FF,  2, 0, 0, 0, 0, 0,   8191,    1,  2, 0, 1, 0, 3,          10);
    vecs[10] = mk(8'h01, 16'h0001,  1, 0, 0, 0, 0, 0,      0,    1,  1, 0, 1, 0, 3,          10);
    vecs[11] = mk(8'h01, 16'h03E8, 20, 0, 0, 0, 0, 7,    800,    1, 20, 0, 1, 0, 3 + LEN_ERR, 10);

    rv[0] = '{0, 0};  rv[1] = '{9, 0};  rv[2] = '{10, 1}; rv[3] = '{3, 1};
    rv[4] = '{0, 0};  rv[5] = '{5, 0};  rv[6] = '{12, 1}; rv[7] = '{1, 1};
    rv[8] = '{0, 0};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("reset_flags", int'({wr_en_a, wr_en_b, rd_en_a, rd_en_b, freq_upd_a, freq_upd_b}), 0);
    chk("reset_freq_a", int'(freq_a), 0);
    chk("reset_freq_b", int'(freq_b), 0);
    chk("reset_drop", int'(drop_cnt), 0);
    chk("reset_err", int'(err_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Readout hysteresis on A
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      wr_data_count_a = CNT_W'(rv[i].cnt);
      if (rv[i].cnt == 10) begin
        #1 chk("rd_en_a_not_comb", int'(rd_en_a), 0);
      end
      @(negedge clk);
      chk($sformatf("rd_en_a_cnt%0d_step%0d", rv[i].cnt, i), int'(rd_en_a), rv[i].rd);
    end
    // B is independent of A
    @(negedge clk) wr_data_count_b = CNT_W'(10);
    @(negedge clk);
    chk("rd_en_b_start", int'(rd_en_b), 1);
    chk("rd_en_a_indep", int'(rd_en_a), 0);
    wr_data_count_b = CNT_W'(0);
    @(negedge clk);
    chk("rd_en_b_stop", int'(rd_en_b), 0);

    // Packet table
    for (int k = 0; k < 12; k++) begin
      snap();
      send_pkt(vecs[k], 16 * k + 3);
      idle(4);
      chk($sformatf("v%0d_freq_a", k), int'(freq_a), vecs[k].fa);
      chk($sformatf("v%0d_freq_b", k), int'(freq_b), vecs[k].fb);
      chk($sformatf("v%0d_writes_a", k), n_wa - wa0, vecs[k].wa);
      chk($sformatf("v%0d_writes_b", k), n_wb - wb0, vecs[k].wb);
      chk($sformatf("v%0d_upd_a", k), n_ua - ua0, vecs[k].ua);
      chk($sformatf("v%0d_upd_b", k), n_ub - ub0, vecs[k].ub);
      chk($sformatf("v%0d_err_cnt", k), int'(err_cnt), vecs[k].err);
      chk($sformatf("v%0d_drop_cnt", k), int'(drop_cnt), vecs[k].drop);
    end

    // Back-to-back: second header starts the cycle after rec_pkt_done
    snap();
    send_pkt(mk(8'h02, 16'h0032, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 101);
    send_pkt(mk(8'h01, 16'h00C8, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 201);
    idle(4);
    chk("b2b_freq_a", int'(freq_a), 160);
    chk("b2b_freq_b", int'(freq_b), 40);
    chk("b2b_writes_a", n_wa - wa0, 2);
    chk("b2b_writes_b", n_wb - wb0, 3);
    chk("b2b_err_cnt", int'(err_cnt), 3 + LEN_ERR);

    // Latency: write 1 cycle after byte, frequency 2 cycles after low byte
    @(negedge clk) begin udp_rec_en = 1'b1; udp_rec_data = 8'h02; rec_byte_num = 16'd4; end
    @(negedge clk) udp_rec_data = 8'h01;
    @(negedge clk) udp_rec_data = 8'hF4;
    @(negedge clk) begin udp_rec_data = 8'h5A; rec_pkt_done = 1'b1; q_b.push_back(8'h5A); end
    chk("lat_upd_b_not_early", int'(freq_upd_b), 0);
    @(negedge clk) begin udp_rec_en = 1'b0; rec_pkt_done = 1'b0; end
    chk("lat_upd_b", int'(freq_upd_b), 1);
    chk("lat_freq_b", int'(freq_b), 400);
    chk("lat_wr_en_b", int'(wr_en_b), 1);
    chk("lat_fifo_in_b", int'(fifo_in_b), 8'h5A);
    @(negedge clk);
    chk("lat_upd_b_pulse", int'(freq_upd_b), 0);
    chk("lat_wr_en_b_pulse", int'(wr_en_b), 0);
    idle(2);

    // Mid-packet asynchronous reset
    @(negedge clk) begin udp_rec_en = 1'b1; udp_rec_data = 8'h02; end
    @(negedge clk) udp_rec_data = 8'h12;
    @(negedge clk) udp_rec_data = 8'h34;
    @(negedge clk) begin udp_rec_data = 8'hAA; q_b.push_back(8'hAA); end
    @(negedge clk) udp_rec_en = 1'b0;
    chk("mid_freq_b_before", int'(freq_b), 3728);
    chk("mid_wr_en_b_before", int'(wr_en_b), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_wr_en_b", int'(wr_en_b), 0);
    chk("mid_freq_b", int'(freq_b), 0);
    chk("mid_err", int'(err_cnt), 0);
    chk("mid_drop", int'(drop_cnt), 0);
    q_a.delete(); q_b.delete();
    @(negedge clk) rst_n = 1'b1;
    snap();
    send_pkt(mk(8'hBB, 16'hCC00, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    idle(4);
    chk("post_rst_err", int'(err_cnt), 1);
    chk("post_rst_writes", (n_wa - wa0) + (n_wb - wb0), 0);
    chk("post_rst_upd", (n_ua - ua0) + (n_ub - ub0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
